// File: rtl/cosine_gen.sv
// rtl/cosine_gen.sv - cosine sample source: phase accumulator, quarter-wave table, sample-rate divider
module cosine_gen #(
    parameter int ACC_W = 16,
    parameter int DIV   = 4,
    parameter int AMP   = 127
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              RESTART,
    input  logic [ACC_W-1:0]  FREQ,
    output logic signed [7:0] COSINE,
    output logic              SAMPLE_VALID,
    output logic              CYCLE_START,
    output logic [7:0]        PHASE
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    // Full-scale quarter cosine, round(127*cos(pi/2*k/64)); rescaled to AMP below.
    function automatic int q_full(input int k);
        case (k)
            0: return 127;  1: return 127;  2: return 127;  3: return 127;
            4: return 126;  5: return 126;  6: return 126;  7: return 125;
            8: return 125;  9: return 124; 10: return 123; 11: return 122;
           12: return 122; 13: return 121; 14: return 120; 15: return 118;
           16: return 117; 17: return 116; 18: return 115; 19: return 113;
           20: return 112; 21: return 111; 22: return 109; 23: return 107;
           24: return 106; 25: return 104; 26: return 102; 27: return 100;
           28: return 98;  29: return 96;  30: return 94;  31: return 92;
           32: return 90;  33: return 88;  34: return 85;  35: return 83;
           36: return 81;  37: return 78;  38: return 76;  39: return 73;
           40: return 71;  41: return 68;  42: return 65;  43: return 63;
           44: return 60;  45: return 57;  46: return 54;  47: return 51;
           48: return 49;  49: return 46;  50: return 43;  51: return 40;
           52: return 37;  53: return 34;  54: return 31;  55: return 28;
           56: return 25;  57: return 22;  58: return 19;  59: return 16;
           60: return 12;  61: return 9;   62: return 6;   63: return 3;
           default: return 0;
        endcase
    endfunction

    function automatic int q_amp(input int k);
        return (q_full(k) * AMP * 2 + 127) / 254;
    endfunction

    logic [6:0] rom [0:64];
    for (genvar k = 0; k <= 64; k++) begin : g_rom
        assign rom[k] = 7'(q_amp(k));
    end

    logic [CNT_W-1:0] div_cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic             strobe;
    logic             first_flag;
    logic [7:0]       addr_r;
    logic             wrap_r;
    logic             start_r;
    logic             s1_valid;
    logic [6:0]       idx;
    logic signed [7:0] mag;
    logic signed [7:0] mapped;

    assign strobe  = EN && (div_cnt == CNT_W'(DIV - 1));
    assign acc_sum = {1'b0, acc} + {1'b0, FREQ};

    always_comb begin
        idx    = addr_r[6] ? (7'd64 - {1'b0, addr_r[5:0]}) : {1'b0, addr_r[5:0]};
        mag    = {1'b0, rom[idx]};
        mapped = (addr_r[7] ^ addr_r[6]) ? -mag : mag;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_cnt <= '0;
        end else if (RESTART) begin
            div_cnt <= '0;
        end else if (EN) begin
            div_cnt <= (div_cnt == CNT_W'(DIV - 1)) ? '0 : div_cnt + CNT_W'(1);
        end
    end

    // Stage 1: latch the address and advance phase; wrap_r remembers the carry
    // that starts the period of the *next* sample.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc        <= '0;
            addr_r     <= '0;
            wrap_r     <= 1'b0;
            start_r    <= 1'b0;
            s1_valid   <= 1'b0;
            first_flag <= 1'b1;
        end else if (RESTART) begin
            acc        <= '0;
            wrap_r     <= 1'b0;
            start_r    <= 1'b0;
            s1_valid   <= 1'b0;
            first_flag <= 1'b1;
        end else begin
            s1_valid <= strobe;
            if (strobe) begin
                addr_r     <= acc[ACC_W-1 -: 8];
                acc        <= acc_sum[ACC_W-1:0];
                wrap_r     <= acc_sum[ACC_W];
                start_r    <= first_flag | wrap_r;
                first_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            COSINE       <= '0;
            PHASE        <= '0;
            SAMPLE_VALID <= 1'b0;
            CYCLE_START  <= 1'b0;
        end else if (RESTART) begin
            COSINE       <= '0;
            PHASE        <= '0;
            SAMPLE_VALID <= 1'b0;
            CYCLE_START  <= 1'b0;
        end else begin
            SAMPLE_VALID <= s1_valid;
            CYCLE_START  <= s1_valid & start_r;
            if (s1_valid) begin
                COSINE <= mapped;
                PHASE  <= addr_r;
            end
        end
    end

endmodule

// File: doc/cosine_gen.md
Name: cosine_gen

Overview:
- Cosine sample source that sits directly upstream of the FIR stage. It supplies the 8-bit signed sample stream that the interface top registers as its cosine signal and forwards to the filter.
- Built from a phase accumulator, a quarter-wave lookup table with quadrant symmetry, and a programmable sample-rate divider that produces one sample strobe every DIV clocks.
- A RESTART input realigns the waveform to phase 0. The top pulses it when the output mode switch toggles.

Parameters:
- ACC_W, 16, phase accumulator width. The top 8 bits form the table address.
- DIV, 4, CLK cycles per output sample; must be ≥1.
- AMP, 127, peak amplitude used to build the table; must be ≤127.

Ports:
- CLK  input  1  system clock
- RST  input  1  reset, asynchronous, active-low
- EN  input  1  run enable; 0 freezes sample production
- RESTART  input  1  single-cycle pulse: realign phase to 0
- FREQ  input  ACC_W  phase increment per sample, sampled on each strobe
- COSINE  output  8  signed sample
- SAMPLE_VALID  output  1  one-cycle pulse when COSINE updates
- CYCLE_START  output  1  qualifies SAMPLE_VALID; marks the first sample of a waveform period
- PHASE  output  8  table address of the sample currently on COSINE

Behaviour:
- Reset (RST=0, asynchronous): clears the accumulator, divider and pipeline. Output reset values: COSINE=0, SAMPLE_VALID=0, CYCLE_START=0, PHASE=0. The first-sample flag is set.
- Table: Q[k]=round(AMP*cos(pi/2*k/64)) for k=0..64, so Q[0]=127, Q[32]=90, Q[64]=0.
- Address mapping: a = acc[ACC_W-1:ACC_W-8]; quadrant = a[7:6]; i = a[5:0].
  - Quadrant 0: Q[i]
  - Quadrant 1: -Q[64-i]
  - Quadrant 2: -Q[i]
  - Quadrant 3: Q[64-i]
  - All results lie in -127..127; -128 is never produced.
- Divider: div_cnt counts 0..DIV-1 while EN=1. The strobe fires in the cycle where div_cnt==DIV-1 and EN=1; div_cnt then wraps to 0. With DIV=1 the strobe fires every cycle.
- Pipeline stage 1, on the strobe edge:
  - addr_r <= a
  - acc <= acc + FREQ, modulo 2^ACC_W
  - carry-out is recorded in wrap_r
  - first_r <= first-sample flag; the flag then clears
- Pipeline stage 2, the next edge:
  - COSINE <= mapped value of addr_r
  - PHASE <= addr_r
  - SAMPLE_VALID <= 1
  - CYCLE_START <= first_r OR (carry recorded by the previous strobe)
- Latency: COSINE changes 2 clock edges after the strobe cycle's edge. SAMPLE_VALID is high for exactly 1 cycle per strobe; otherwise it is 0.
- Holding: COSINE and PHASE hold their values between strobes.
- EN=0:
  - div_cnt freezes and no new strobe occurs.
  - A sample already in stage 1 still completes.
  - When EN returns to 1, counting resumes from the frozen div_cnt value.
- RESTART=1, at the clock edge:
  - acc, div_cnt and pipeline valid bits clear.
  - COSINE=0 and SAMPLE_VALID=0 for that cycle; the first-sample flag is set.
  - The next sample is address 0 (+127) with CYCLE_START=1, emitted DIV+2 cycles after the RESTART edge when EN=1.
- RESTART coinciding with a strobe: RESTART wins, and the strobe and any in-flight sample are discarded.
- FREQ=0: every sample is 127. CYCLE_START fires only on the first sample after reset or RESTART.
- FREQ changes mid-period: the new increment takes effect at the next strobe. There is no phase discontinuity beyond the step change.

Test Plan:
- Reset release, EN=1, DIV=4, FREQ=0x0100:
  - First SAMPLE_VALID 6 cycles after reset release, carrying COSINE=127, PHASE=0, CYCLE_START=1.
  - Samples 32/64/96/128/192 = 90/0/-90/-127/0.
  - Sample 256 = 127 with CYCLE_START=1.
  - SAMPLE_VALID spacing is exactly 4 cycles.
- FREQ=0x4000, DIV=1:
  - COSINE sequence 127, 0, -127, 0 repeating.
  - SAMPLE_VALID high continuously; CYCLE_START every 4th sample.
- RESTART pulse mid-run at sample 100, DIV=4:
  - COSINE=0 with no SAMPLE_VALID in the RESTART cycle.
  - 127 with CYCLE_START=1 arrives 6 cycles after the RESTART edge; the sequence restarts at PHASE 0.
- EN deasserted for 20 cycles mid-period: no SAMPLE_VALID during the hold, and COSINE and PHASE are unchanged. The next sample after re-enable continues the sequence with no skip.
- RST asserted asynchronously mid-cycle, between clock edges:
  - Outputs go to 0 immediately, without a clock edge.
  - After release the sequence matches the first scenario exactly.
- RESTART in the same cycle as a strobe: that strobe's sample is never emitted, and the next emitted sample is 127 with CYCLE_START=1.
